pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, async active-high reset.
REQ-002 SHALL have these inputs, all 4 bits except where noted: D_icode_i (icode in Decode); d_srcA_i and d_srcB_i (decode source registers); E_icode_i; E_dstM_i; M_icode_i.
REQ-003 SHALL have these further inputs: e_Cnd_i input 1 (branch condition from Execute); m_stat_i input 3 (Memory-stage status); W_stat_i input 3 (Write-back status).
REQ-004 SHALL have these 1-bit outputs: F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o (pipeline-register controls).
REQ-005 SHALL have these counter and state outputs: state_o output 2 (FSM state); cycle_cnt_o output 32 (run cycles); stall_cnt_o output 32 (fetch-stall cycles).
REQ-006 SHALL use the define.v constants: IMRMOVQ=5, IJXX=7, IRET=9, IPOPQ=B, RNONE=F, SAOK=1.

Function
REQ-007 SHALL implement FSM states RUN=0, RET=1 and HALT=2; encoding 3 is unreachable and SHALL behave as HALT.
REQ-008 SHALL raise load_use when E_icode_i is IMRMOVQ or IPOPQ, E_dstM_i is not RNONE, and E_dstM_i equals d_srcA_i or d_srcB_i.
REQ-009 SHALL raise mispredict when E_icode_i is IJXX and e_Cnd_i is 0.
REQ-010 SHALL raise exc_m when m_stat_i is not SAOK, and exc_w when W_stat_i is not SAOK.
REQ-011 SHALL raise ret_d when D_icode_i is IRET, the state is RUN, load_use is 0 and mispredict is 0.
REQ-012 SHALL compute all stall and bubble outputs combinationally from the current state and the current inputs (zero latency).
REQ-013 SHALL drive, in RUN or RET: F_stall_o = load_use | ret_d | (state==RET).
REQ-014 SHALL drive, in RUN or RET: D_stall_o = load_use.
REQ-015 SHALL drive, in RUN or RET: D_bubble_o = !load_use & (mispredict | ret_d | state==RET).
REQ-016 SHALL drive, in RUN or RET: E_bubble_o = load_use | mispredict.
REQ-017 SHALL drive, in RUN or RET: M_bubble_o = exc_m | exc_w, and W_stall_o = exc_w.
REQ-018 SHALL drive, in HALT: F_stall_o, D_stall_o, E_bubble_o, M_bubble_o and W_stall_o = 1, and D_bubble_o = 0.
REQ-019 SHALL never assert D_stall_o and D_bubble_o in the same cycle.
REQ-020 SHALL move RUN->RET on a clock edge with ret_d=1, loading an internal 2-bit ret counter with 2.
REQ-021 SHALL, in RET, decrement the ret counter each cycle and return RET->RUN on the edge where the counter is 1, so RET lasts exactly 2 cycles and a ret gives 3 fetch-stall cycles in total.
REQ-022 SHALL move from RUN or RET to HALT on any edge with exc_w=1; this has priority over every other transition, including a RET in progress.
REQ-023 SHALL leave HALT only through rst_i.
REQ-024 SHALL keep the ret counter at 0 whenever the state is not RET.
REQ-025 SHALL increment cycle_cnt_o on every edge where the state is RUN or RET.
REQ-026 SHALL increment stall_cnt_o on every edge where the state is RUN or RET and F_stall_o=1.
REQ-027 SHALL saturate both counters at FFFF_FFFF, with no wrap, and hold both counters in HALT.
REQ-028 SHALL count the cycle of the edge that enters HALT.

Reset
REQ-029 SHALL, while rst_i=1, immediately force the state to RUN, the ret counter to 0, and cycle_cnt_o and stall_cnt_o to 0, independent of clk_i.
REQ-030 SHALL, with all inputs at SAOK and no hazard after reset, drive every stall and bubble output to 0.
REQ-031 SHALL, on reset asserted mid-RET or in HALT, abort that state, with no residual F_stall_o on the first cycle after release.

Verification
REQ-032 SHALL pass the load-use case: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; with E_dstM=F -> all 0.
REQ-033 SHALL pass the ret case: D_icode=9 for one cycle, then 0 -> F_stall=1 and D_bubble=1 for 3 consecutive cycles, state_o sequence 0,1,1,0, and stall_cnt_o +3.
REQ-034 SHALL pass the mispredict case: E_icode=7, e_Cnd=0, D_icode=9 -> D_bubble=1, E_bubble=1, F_stall=0, state stays RUN; with e_Cnd=1 -> no bubbles.
REQ-035 SHALL pass the load-use plus ret case: E_icode=B, E_dstM=4, d_srcB=4, D_icode=9 -> D_stall=1, D_bubble=0, no RET entry; clearing load_use the next cycle -> RET is entered.
REQ-036 SHALL pass the exception case: m_stat=3 -> M_bubble=1 only; W_stat=2 during RET -> W_stall=1, state_o=2 the next cycle, all HALT outputs asserted, counters frozen.
REQ-037 SHALL pass the async reset and saturation case: rst_i pulsed between clock edges while in HALT -> state_o=0 and counters 0 without a clock edge; cycle_cnt_o forced near FFFF_FFFF -> holds at FFFF_FFFF.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-stage status inputs and pipeline-register control outputs
// shared between the stage logic (master) and the hazard controller (slave).
interface pipe_ctrl_if;
  logic [3:0]  D_icode_i;
  logic [3:0]  d_srcA_i;
  logic [3:0]  d_srcB_i;
  logic [3:0]  E_icode_i;
  logic [3:0]  E_dstM_i;
  logic [3:0]  M_icode_i;
  logic        e_Cnd_i;
  logic [2:0]  m_stat_i;
  logic [2:0]  W_stat_i;
  logic        F_stall_o;
  logic        D_stall_o;
  logic        D_bubble_o;
  logic        E_bubble_o;
  logic        M_bubble_o;
  logic        W_stall_o;
  logic [1:0]  state_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] stall_cnt_o;

  modport master (
    output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i,
           e_Cnd_i, m_stat_i, W_stat_i,
    input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
           state_o, cycle_cnt_o, stall_cnt_o
  );

  modport slave (
    input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, M_icode_i,
           e_Cnd_i, m_stat_i, W_stat_i,
    output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
           state_o, cycle_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-style pipeline hazard controller: combinational stall/bubble generation,
// a RUN/RET/HALT sequencer and saturating run/fetch-stall cycle counters.
module pipe_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  pipe_ctrl_if.slave bus
);

  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RET  = 2'd1,
    ST_HALT = 2'd2,
    ST_RSVD = 2'd3
  } state_e;

  state_e      state_r;
  state_e      state_nxt_s;
  logic [1:0]  ret_cnt_r;
  logic [1:0]  ret_cnt_nxt_s;
  logic [31:0] cycle_cnt_r;
  logic [31:0] stall_cnt_r;

  logic load_use_s, mispredict_s, exc_m_s, exc_w_s, ret_d_s;
  logic active_s;
  logic f_stall_s, d_stall_s, d_bubble_s, e_bubble_s, m_bubble_s, w_stall_s;
  logic m_icode_unused_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  assign m_icode_unused_s = ^bus.M_icode_i;

  // Hazard and exception detection from the current stage contents
  always_comb begin
    load_use_s   = ((bus.E_icode_i == IMRMOVQ) || (bus.E_icode_i == IPOPQ)) &&
                   (bus.E_dstM_i != RNONE) &&
                   ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    mispredict_s = (bus.E_icode_i == IJXX) && !bus.e_Cnd_i;
    exc_m_s      = (bus.m_stat_i != SAOK);
    exc_w_s      = (bus.W_stat_i != SAOK);
    ret_d_s      = (bus.D_icode_i == IRET) && (state_r == ST_RUN) &&
                   !load_use_s && !mispredict_s;
  end

  // Pipeline-register controls; the reserved encoding is treated as HALT
  always_comb begin
    f_stall_s  = 1'b0;
    d_stall_s  = 1'b0;
    d_bubble_s = 1'b0;
    e_bubble_s = 1'b0;
    m_bubble_s = 1'b0;
    w_stall_s  = 1'b0;
    active_s   = 1'b0;
    case (state_r)
      ST_RUN, ST_RET: begin
        active_s   = 1'b1;
        f_stall_s  = load_use_s | ret_d_s | (state_r == ST_RET);
        d_stall_s  = load_use_s;
        d_bubble_s = !load_use_s & (mispredict_s | ret_d_s | (state_r == ST_RET));
        e_bubble_s = load_use_s | mispredict_s;
        m_bubble_s = exc_m_s | exc_w_s;
        w_stall_s  = exc_w_s;
      end
      default: begin
        f_stall_s  = 1'b1;
        d_stall_s  = 1'b1;
        e_bubble_s = 1'b1;
        m_bubble_s = 1'b1;
        w_stall_s  = 1'b1;
      end
    endcase
  end

  // Next-state logic; a write-back exception overrides any ret in progress
  always_comb begin
    state_nxt_s   = state_r;
    ret_cnt_nxt_s = 2'd0;
    case (state_r)
      ST_RUN: begin
        if (exc_w_s) begin
          state_nxt_s = ST_HALT;
        end else if (ret_d_s) begin
          state_nxt_s   = ST_RET;
          ret_cnt_nxt_s = 2'd2;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RET: begin
        if (exc_w_s) begin
          state_nxt_s = ST_HALT;
        end else if (ret_cnt_r == 2'd1) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s   = ST_RET;
          ret_cnt_nxt_s = ret_cnt_r - 2'd1;
        end
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // State, ret counter and saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_RUN;
      ret_cnt_r   <= 2'd0;
      cycle_cnt_r <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      ret_cnt_r <= ret_cnt_nxt_s;
      if (active_s) begin
        cycle_cnt_r <= sat_inc(cycle_cnt_r);
        if (f_stall_s) begin
          stall_cnt_r <= sat_inc(stall_cnt_r);
        end
      end
    end
  end

  assign bus.F_stall_o   = f_stall_s;
  assign bus.D_stall_o   = d_stall_s;
  assign bus.D_bubble_o  = d_bubble_s;
  assign bus.E_bubble_o  = e_bubble_s;
  assign bus.M_bubble_o  = m_bubble_s;
  assign bus.W_stall_o   = w_stall_s;
  assign bus.state_o     = state_r;
  assign bus.cycle_cnt_o = cycle_cnt_r;
  assign bus.stall_cnt_o = stall_cnt_r;

endmodule
